// File: rtl/reconstructor_4b_pkg.sv
// Shared definitions for the dividend reconstructor: FSM encoding, default operand width,
// and the iteration-counter width helper.
package reconstructor_4b_pkg;

   localparam int W_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Keeps the counter at least one bit wide when W is 1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/reconstructor_4b_contador_iter.sv
// Iteration counter for the shift-add loop; synchronous clear/enable, flags the last iteration.
// Zero latency on o_last; no backpressure (driven purely by the FSM).
module contador_iter
   import reconstructor_4b_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = cnt_width(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic          o_last
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == CW'(W - 1));

endmodule

// File: rtl/reconstructor_4b.sv
// Rebuilds dividend = q*d + r with a W-step shift-add; done pulses W+1 cycles after start is accepted.
// start is ignored outside IDLE (never queued). RECON_CHECK_EN enables the exp_num match output.
module reconstructor_4b
   import reconstructor_4b_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   q,
   input  logic [W-1:0]   d,
   input  logic [W-1:0]   r,
   input  logic [W-1:0]   exp_num,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product,
   output logic           ovf,
   output logic           match
);

   localparam int CW = cnt_width(W);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_calc;
   logic             w_last;
   logic [CW-1:0]    w_cnt;

   logic [2*W-1:0]   r_acc;
   logic [2*W-1:0]   r_mcand;
   logic [W-1:0]     r_mplier;
   logic [2*W-1:0]   r_product;
   logic             r_ovf;
   logic [2*W-1:0]   w_acc_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_calc      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            w_calc = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   contador_iter #(
      .W  (W),
      .CW (CW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_accept),
      .i_en   (w_calc),
      .o_cnt  (w_cnt),
      .o_last (w_last)
   );

   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   // Result registers load on the last CALC edge so they are already valid in the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_product <= '0;
         r_ovf     <= 1'b0;
      end else if (w_accept) begin
         r_mplier <= q;
         r_mcand  <= {{W{1'b0}}, d};
         r_acc    <= {{W{1'b0}}, r};
      end else if (w_calc) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (w_last) begin
            r_product <= w_acc_nxt;
            r_ovf     <= |w_acc_nxt[2*W-1:W];
         end
      end
   end

`ifdef RECON_CHECK_EN
   logic [W-1:0] r_exp;
   logic         r_match;
   logic         w_unused;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp   <= '0;
         r_match <= 1'b0;
      end else if (w_accept) begin
         r_exp <= exp_num;
      end else if (w_calc && w_last) begin
         r_match <= (w_acc_nxt == {{W{1'b0}}, r_exp});
      end
   end

   assign match    = r_match;
   assign w_unused = ^w_cnt;
`else
   logic w_unused;

   assign match    = 1'b0;
   assign w_unused = ^{w_cnt, exp_num};
`endif

   assign busy    = (r_state == S_CALC);
   assign done    = (r_state == S_DONE);
   assign product = r_product;
   assign ovf     = r_ovf;

endmodule
